// File: rtl/div_sequencer_if.sv
// Handshake and operand bundle between execute-stage control and the divide sequencer.
interface div_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start_in;
  logic [2:0]      funct3_in;
  logic [XLEN-1:0] rs1_in;
  logic [XLEN-1:0] rs2_in;
  logic            kill_in;
  logic            busy_out;
  logic            done_out;
  logic [XLEN-1:0] result_out;

  modport master (
    output start_in, funct3_in, rs1_in, rs2_in, kill_in,
    input  busy_out, done_out, result_out
  );

  modport slave (
    input  start_in, funct3_in, rs1_in, rs2_in, kill_in,
    output busy_out, done_out, result_out
  );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring divide, one quotient bit per clock.
// Divide-by-zero and signed overflow are resolved at accept and finish in a single cycle.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst,
  div_sequencer_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t          r_state;
  state_t          w_next;

  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_divisor;
  logic [CW-1:0]   r_count;
  logic            r_negQ;
  logic            r_negR;
  logic            r_isRem;
  logic [XLEN-1:0] r_result;

  logic            w_accept;
  logic            w_signed;
  logic            w_rs1Neg;
  logic            w_rs2Neg;
  logic [XLEN-1:0] w_absRs1;
  logic [XLEN-1:0] w_absRs2;
  logic            w_divZero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_specQuo;
  logic [XLEN-1:0] w_specRem;
  logic [XLEN:0]   w_partial;
  logic [XLEN:0]   w_trial;
  logic            w_lastIter;
  logic [XLEN-1:0] w_fixQuo;
  logic [XLEN-1:0] w_fixRem;

  // Decode the request and prepare magnitudes and special-case results for accept
  always_comb begin
    w_accept   = bus.start_in && bus.funct3_in[2] && !bus.kill_in &&
                 ((r_state == IDLE) || (r_state == DONE));
    w_signed   = ~bus.funct3_in[0];
    w_rs1Neg   = w_signed & bus.rs1_in[XLEN-1];
    w_rs2Neg   = w_signed & bus.rs2_in[XLEN-1];
    w_absRs1   = w_rs1Neg ? -bus.rs1_in : bus.rs1_in;
    w_absRs2   = w_rs2Neg ? -bus.rs2_in : bus.rs2_in;
    w_divZero  = (bus.rs2_in == '0);
    w_ovf      = w_signed && (bus.rs1_in == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_in == '1);
    w_special  = w_divZero | w_ovf;
    w_specQuo  = w_divZero ? '1 : bus.rs1_in;
    w_specRem  = w_divZero ? bus.rs1_in : '0;
    // The partial remainder keeps its top bit so divisors above 2^(XLEN-1) still work
    w_partial  = {r_rem, r_quo[XLEN-1]};
    w_trial    = w_partial - {1'b0, r_divisor};
    w_lastIter = (r_count == CW'(XLEN - 1));
    w_fixQuo   = r_negQ ? -r_quo : r_quo;
    w_fixRem   = r_negR ? -r_rem : r_rem;
  end

  // State register; reset abandons any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state selection; a flush overrides everything, including a same-cycle request
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) w_next = w_special ? DONE : CALC;
        else          w_next = IDLE;
      end
      CALC:    if (w_lastIter) w_next = FIXUP;
      FIXUP:   w_next = DONE;
      default: w_next = IDLE;
    endcase
    if (bus.kill_in) w_next = IDLE;
  end

  // Operand latch, restoring-divide iterations and sign fixup of the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_count   <= '0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_isRem   <= 1'b0;
      r_result  <= '0;
    end else if (!bus.kill_in) begin
      if (w_accept) begin
        r_isRem   <= bus.funct3_in[1];
        r_negQ    <= w_rs1Neg ^ w_rs2Neg;
        r_negR    <= w_rs1Neg;
        r_divisor <= w_absRs2;
        r_quo     <= w_absRs1;
        r_rem     <= '0;
        r_count   <= '0;
        if (w_special) r_result <= bus.funct3_in[1] ? w_specRem : w_specQuo;
      end else if (r_state == CALC) begin
        r_count <= r_count + 1'b1;
        r_rem   <= w_trial[XLEN] ? w_partial[XLEN-1:0] : w_trial[XLEN-1:0];
        r_quo   <= {r_quo[XLEN-2:0], ~w_trial[XLEN]};
      end else if (r_state == FIXUP) begin
        r_result <= r_isRem ? w_fixRem : w_fixQuo;
      end
    end
  end

  assign bus.busy_out   = (r_state == CALC) || (r_state == FIXUP);
  assign bus.done_out   = (r_state == DONE);
  assign bus.result_out = r_result;
endmodule

// File: tb/tb_div_sequencer.sv
// Directed testbench for div_sequencer with hand-computed results and latencies.
module tb_div_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   lat;

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  div_sequencer_if #(.XLEN(32)) bus();
  div_sequencer #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Present a request for one rising edge (the cycle the caller is in is cycle 0)
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bus.start_in  = 1'b1;
    bus.funct3_in = f3;
    bus.rs1_in    = a;
    bus.rs2_in    = b;
    @(posedge clk);
    #1;
    bus.start_in  = 1'b0;
    bus.funct3_in = 3'b000;
    bus.rs1_in    = '0;
    bus.rs2_in    = '0;
  endtask

  // Count cycles after the accept edge until done_out; 0 means it never came
  task automatic waitDone(input int budget, output int cycles);
    cycles = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (bus.done_out === 1'b1) begin
        cycles = c;
        break;
      end
    end
  endtask

  // One operation from IDLE with latency and result checks
  task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expRes, input int expLat);
    int l;
    @(negedge clk);
    applyStimulus(f3, a, b);
    waitDone(60, l);
    checkOutput({tag, " latency"}, l, expLat);
    checkOutput({tag, " result"}, bus.result_out, expRes);
  endtask

  // Directed test sequence
  initial begin
    rst = 1'b1;
    bus.start_in  = 1'b0;
    bus.funct3_in = 3'b000;
    bus.rs1_in    = '0;
    bus.rs2_in    = '0;
    bus.kill_in   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy",   {31'b0, bus.busy_out}, 32'd0);
    checkOutput("reset done",   {31'b0, bus.done_out}, 32'd0);
    checkOutput("reset result", bus.result_out, 32'd0);
    rst = 1'b0;

    runOp("divu 100/7", 3'b101, 32'd100, 32'd7, 32'd14, 34);
    runOp("remu 100/7", 3'b111, 32'd100, 32'd7, 32'd2, 34);
    runOp("div -7/2",   3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    runOp("rem -7/2",   3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    runOp("divu by 0",  3'b101, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1);
    runOp("rem by 0",   3'b110, 32'h0000_1234, 32'd0, 32'h0000_1234, 1);
    runOp("div ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    runOp("rem ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    runOp("divu big",   3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 34);
    runOp("remu big",   3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 34);
    runOp("div -100/-7", 3'b100, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 34);
    runOp("rem -100/-7", 3'b110, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 34);

    // Non-divide funct3 is not accepted
    @(negedge clk);
    applyStimulus(3'b001, 32'd50, 32'd5);
    checkOutput("ignored busy", {31'b0, bus.busy_out}, 32'd0);
    waitDone(40, lat);
    checkOutput("ignored no done", lat, 0);
    checkOutput("ignored result", bus.result_out, 32'hFFFF_FFFE);

    // A second request while busy must not disturb the running divide
    @(negedge clk);
    applyStimulus(3'b101, 32'd1000, 32'd10);
    repeat (4) @(negedge clk);
    checkOutput("busy in calc", {31'b0, bus.busy_out}, 32'd1);
    bus.start_in  = 1'b1;
    bus.funct3_in = 3'b111;
    bus.rs1_in    = 32'd5;
    bus.rs2_in    = 32'd3;
    @(posedge clk);
    #1;
    bus.start_in  = 1'b0;
    waitDone(60, lat);
    checkOutput("busy start latency", lat, 30);
    checkOutput("busy start result", bus.result_out, 32'd100);

    // Flush in cycle 10 of a divide
    @(negedge clk);
    applyStimulus(3'b101, 32'h0000_FFFF, 32'd3);
    repeat (10) @(negedge clk);
    bus.kill_in = 1'b1;
    @(posedge clk);
    #1;
    bus.kill_in = 1'b0;
    @(negedge clk);
    checkOutput("kill busy", {31'b0, bus.busy_out}, 32'd0);
    waitDone(40, lat);
    checkOutput("kill no done", lat, 0);
    checkOutput("kill result", bus.result_out, 32'd100);

    // Flush beats a same-cycle special-case request
    @(negedge clk);
    bus.kill_in = 1'b1;
    applyStimulus(3'b101, 32'h0000_1234, 32'd0);
    bus.kill_in = 1'b0;
    waitDone(5, lat);
    checkOutput("kill prio no done", lat, 0);
    checkOutput("kill prio result", bus.result_out, 32'd100);

    runOp("divu 9/3", 3'b101, 32'd9, 32'd3, 32'd3, 34);

    // Back-to-back: new request issued in the DONE cycle
    runOp("b2b first", 3'b101, 32'd100, 32'd7, 32'd14, 34);
    applyStimulus(3'b111, 32'd1000, 32'd7);
    waitDone(60, lat);
    checkOutput("b2b latency", lat, 34);
    checkOutput("b2b result", bus.result_out, 32'd6);

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    applyStimulus(3'b101, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("async rst busy",   {31'b0, bus.busy_out}, 32'd0);
    checkOutput("async rst done",   {31'b0, bus.done_out}, 32'd0);
    checkOutput("async rst result", bus.result_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    waitDone(50, lat);
    checkOutput("async rst no done", lat, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
